// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use a shift-add loop and divides use restoring division. Each
// op takes one result bit per cycle for 32 cycles, followed by a sign-fix
// cycle. Divide-by-zero and signed overflow finish straight from PREP.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic [4:0]      RDaddr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      RDaddr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] a_q;        // operand 1; becomes the quotient during division
  logic [31:0] b_q;        // operand 2; shifted right as the multiplier
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;       // destination captured at accept
  logic [63:0] acc_q;      // product, or remainder in [63:32] for divides
  logic [4:0]  cnt_q;
  logic        neg_q;      // product/quotient must be negated
  logic        rneg_q;     // remainder must be negated
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic [4:0]  rdout_q;

  logic        is_div;
  logic        sgn1, sgn2;
  logic        neg1, neg2;
  logic [31:0] abs1_d, abs2_d;
  logic        div_zero, div_ovf, special_d;
  logic [31:0] special_res_d;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] acc_d;
  logic [31:0] a_d, b_d;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] fix_res_d;

  // Operand conditioning, special-case detection, one iteration step and final sign fix
  always_comb begin
    is_div = f3_q[2];
    sgn1   = 1'b0;
    sgn2   = 1'b0;
    case (f3_q)
      3'b001:         begin sgn1 = 1'b1; sgn2 = 1'b1; end  // MULH
      3'b010:         begin sgn1 = 1'b1; sgn2 = 1'b0; end  // MULHSU
      3'b100, 3'b110: begin sgn1 = 1'b1; sgn2 = 1'b1; end  // DIV, REM
      default:        begin sgn1 = 1'b0; sgn2 = 1'b0; end
    endcase
    neg1   = sgn1 & a_q[31];
    neg2   = sgn2 & b_q[31];
    abs1_d = neg1 ? -a_q : a_q;
    abs2_d = neg2 ? -b_q : b_q;

    div_zero  = is_div && (b_q == 32'd0);
    div_ovf   = is_div && !f3_q[0] && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    special_d = div_zero || div_ovf;
    if (div_zero) begin
      special_res_d = f3_q[1] ? a_q : 32'hFFFF_FFFF;
    end else begin
      special_res_d = f3_q[1] ? 32'd0 : 32'h8000_0000;
    end

    // Multiply step: add multiplicand into the upper half, then shift right
    mul_sum   = {1'b0, acc_q[63:32]} + (b_q[0] ? {1'b0, a_q} : 33'd0);
    // Divide step: shift next dividend bit into the remainder, trial subtract.
    // The remainder stays below the divisor, so bit 32 of the difference is
    // the borrow.
    div_shift = {acc_q[63:32], a_q[31]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = ~div_diff[32];
    if (is_div) begin
      acc_d = {(div_ge ? div_diff[31:0] : div_shift[31:0]), 32'd0};
      a_d   = {a_q[30:0], div_ge};
      b_d   = b_q;
    end else begin
      acc_d = {mul_sum, acc_q[31:1]};
      a_d   = a_q;
      b_d   = {1'b0, b_q[31:1]};
    end

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -a_q : a_q;
    rem_fix  = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    case (f3_q)
      3'b000:                 fix_res_d = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_res_d = prod_fix[63:32];
      3'b100, 3'b101:         fix_res_d = quo_fix;
      default:                fix_res_d = rem_fix;
    endcase
  end

  // Control FSM with registered busy/done and the operand/result datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rdout_q  <= '0;
    end else if (kill_i && (state_q != S_IDLE)) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i && !kill_i && (funct_i[9:3] == 7'b0000001)) begin
            a_q     <= data1_i;
            b_q     <= data2_i;
            f3_q    <= funct_i[2:0];
            rd_q    <= RDaddr_i;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          a_q    <= abs1_d;
          b_q    <= abs2_d;
          neg_q  <= neg1 ^ neg2;
          rneg_q <= neg1;
          acc_q  <= '0;
          cnt_q  <= '0;
          if (special_d) begin
            result_q <= special_res_d;
            rdout_q  <= rd_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          result_q <= fix_res_d;
          rdout_q  <= rd_q;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign RDaddr_o = rdout_q;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes operands, funct and destination register directly from the ID/EX pipeline register outputs, and computes one M-extension result over multiple cycles. While it works it drives `busy_o`, which the hazard unit uses to hold IF/ID and ID/EX. It returns the result with a one-cycle `done_o` pulse, which EX/MEM uses to select the ALU result.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width. Only 32 is supported.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset. Synchronous, active-high, highest priority.
- `start_i`  in  1  ID/EX holds an M-extension op. Level signal, sampled only in IDLE.
- `kill_i`  in  1  flush of the instruction in EX. Priority over `start_i`.
- `funct_i`  in  10  `{funct7, funct3}` from ID/EX.
- `data1_i`  in  32  rs1 value (already forwarded).
- `data2_i`  in  32  rs2 value (already forwarded).
- `RDaddr_i`  in  5  destination register.
- `busy_o`  out  1  stall request. High in PREP, CALC and FIX.
- `done_o`  out  1  one-cycle pulse; `result_o` and `RDaddr_o` are valid in that cycle.
- `result_o`  out  32  result; holds its value until the next `done_o`.
- `RDaddr_o`  out  5  destination register captured at accept.

## Operation
- Accept: state is IDLE, `start_i=1`, `kill_i=0` and `funct_i[9:3]=7'b0000001`. On accept, capture the operands, funct3 and RDaddr, and go to PREP. A start with any other funct7 is ignored: no state change, no `done_o`.
- funct3 encoding: 000 MUL (low 32 bits), 001 MULH (s×s, high), 010 MULHSU (s×u, high), 011 MULHU (u×u, high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- PREP:
  - Take the absolute value of each operand treated as signed for the op.
  - Record the result sign: product sign = sign1 XOR sign2; quotient sign likewise; remainder sign = dividend sign.
  - Clear the 64-bit accumulator and the 5-bit counter.
  - Detect special cases; if one applies, go directly to DONE.
- Special cases:
  - Divide by zero: DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: result = 0x80000000. REM of the same pair: result = 0.
- CALC: 32 iterations, one per cycle; the counter counts 0..31, and the 32nd iteration moves to FIX.
  - Multiply: shift-add over 64 bits, one multiplier bit per cycle.
  - Divide: restoring division; one quotient bit per cycle, 33-bit trial subtract.
- FIX: apply two's-complement negation when the recorded sign requires it, select the low or high word (or quotient/remainder), and load `result_o`. Go to DONE.
- DONE: `done_o=1` and `busy_o=0`. ID/EX advances in this cycle; `start_i` is ignored in this cycle. Next state is IDLE.
- Kill: `kill_i=1` in any state other than IDLE returns the unit to IDLE at the next edge. No `done_o` is produced, and `result_o` and `RDaddr_o` are unchanged.
- Reset values: state IDLE; `busy_o=0`, `done_o=0`, `result_o=0`, `RDaddr_o=0`; accumulator and counter cleared. Reset mid-operation aborts the operation with no `done_o`.
- States: IDLE, PREP, CALC, FIX, DONE. Arithmetic uses 64-bit internal width; no X may propagate into `result_o`.

## Timing
- Edge numbering: accept edge = E0. E0 → PREP, E1 → CALC, E2..E33 perform iterations 0..31 (E33 → FIX), E34 → DONE.
  - `done_o` is high for the one cycle after E34.
  - E35 → IDLE.
- `busy_o` is high in the cycles after E0 through E33, i.e. 34 cycles.
- Special-case latency: E1 → DONE, so `done_o` is high for the one cycle after E1.
- Back-to-back: the earliest next accept is at E36 (the unit is in IDLE after E35).
- `busy_o` and `done_o` are registered state decodes with no combinational path from inputs. `busy_o` is low in the accept cycle itself; the hazard unit qualifies its stall with `start_i`.

## Test plan
- MUL: 7 × 0xFFFFFFFD → `done_o` exactly 35 cycles after the accept edge, `result_o`=0xFFFFFFEB. `RDaddr_o` = captured value, e.g. 5.
- Signed high multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Divide/remainder:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with `done_o` 2 cycles after accept and `busy_o` high for exactly 1 cycle:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same pair → 0.
- Control:
  - `start_i` with funct7=0 → no `busy_o`, no `done_o`.
  - A second `start_i` while busy is ignored; the first result is unaffected.
  - `start_i` held high through DONE → no re-issue.
- Abort:
  - `kill_i` at iteration 10 → IDLE next cycle, no `done_o`, `result_o` keeps its old value.
  - `rst_i` mid-CALC → all outputs 0 next cycle.
  - A new op accepted afterwards completes correctly.
